adc_capture_ctrl: RTL and testbench

//  Trigger and acquisition sequencer for the 8-bit ADC sample path. Runs the sample RAM write port:
//  pre-trigger fill, level/edge trigger detect, post-trigger count, then freezes a complete frame.

---
 rtl/adc_pkg.sv | 39 +++
 rtl/adc_capture_ctrl_if.sv | 35 +++
 rtl/adc_trig_detect.sv | 85 ++++++++
 rtl/adc_capture_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
package adc_pkg;

   localparam int unsigned ADDR_W           = 16;
   localparam int unsigned DATA_W           = 8;
   localparam int unsigned SAMPLE_MAX       = (2 ** DATA_W) - 1;
   localparam int unsigned DEF_DEPTH        = 20000;
   localparam int unsigned DEF_PRE_TRIG     = 10000;
   localparam int unsigned DEF_AUTO_TIMEOUT = 65535;
   localparam int unsigned DEF_HYST         = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] sample_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREFILL   = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // Registered RAM write port payload
   typedef struct packed {
      logic    en;
      addr_t   addr;
      sample_t data;
   } wr_port_t;

   // (a - sub) mod depth; the borrow wraps at depth, not at 2**ADDR_W
   function automatic addr_t addr_sub_mod(input addr_t a, input int unsigned sub,
                                          input int unsigned depth);
      int unsigned diff;
      if (32'(a) >= sub) diff = 32'(a) - sub;
      else               diff = 32'(a) + depth - sub;
      return ADDR_W'(diff);
   endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Control/sample/RAM-write bundle between the sample front end and the capture sequencer.
interface adc_capture_ctrl_if;
   import adc_pkg::*;

   logic    sample_en;
   sample_t adc_data;
   sample_t trig_level;
   logic    trig_falling;
   logic    auto_mode;
   logic    single;
   logic    arm;
   logic    abort;
   logic    frame_ack;

   logic    wr_en;
   addr_t   wr_addr;
   sample_t wr_data;
   logic    capture_done;
   addr_t   start_addr;
   logic    trig_forced;
   logic    busy;

   modport master (
      output sample_en, adc_data, trig_level, trig_falling, auto_mode, single,
             arm, abort, frame_ack,
      input  wr_en, wr_addr, wr_data, capture_done, start_addr, trig_forced, busy
   );

   modport slave (
      input  sample_en, adc_data, trig_level, trig_falling, auto_mode, single,
             arm, abort, frame_ack,
      output wr_en, wr_addr, wr_data, capture_done, start_addr, trig_forced, busy
   );

endinterface

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger detector: previous-sample register and crossing compare.
// With ADC_TRIG_HYST_EN defined, a crossing only counts after the signal has been
// seen HYST LSB beyond the opposite side of the level since entering WAIT_TRIG.
module adc_trig_detect
   import adc_pkg::*;
`ifdef ADC_TRIG_HYST_EN
#(
   parameter int unsigned HYST = DEF_HYST
)
`endif
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    sample_en_i,
   input  sample_t sample_i,
   input  sample_t level_i,
   input  logic    falling_i,
   input  logic    busy_i,
   input  logic    in_wait_i,
   input  logic    clr_i,
   output logic    hit_c
);

   sample_t prev_q, prev_d;
   logic    valid_q, valid_d;
   logic    armed_c;
   logic    cross_c;

   // Track the last sample seen while busy; clr forces the next sample to be a non-trigger
   always_comb begin
      prev_d  = prev_q;
      valid_d = valid_q;
      if (busy_i && sample_en_i) begin
         prev_d  = sample_i;
         valid_d = 1'b1;
      end
      if (clr_i) valid_d = 1'b0;
   end

   // Previous-sample state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         valid_q <= valid_d;
      end
   end

`ifdef ADC_TRIG_HYST_EN
   sample_t lo_thr_c, hi_thr_c;
   logic    armed_q, armed_d;

   // Saturated re-arm thresholds and arming state, cleared whenever outside WAIT_TRIG
   always_comb begin
      lo_thr_c = (32'(level_i) >= HYST) ? DATA_W'(32'(level_i) - HYST) : '0;
      hi_thr_c = ((32'(level_i) + HYST) <= SAMPLE_MAX) ? DATA_W'(32'(level_i) + HYST) : '1;
      armed_d  = armed_q;
      if (!in_wait_i) begin
         armed_d = 1'b0;
      end else if (sample_en_i) begin
         if (falling_i ? (sample_i > hi_thr_c) : (sample_i < lo_thr_c)) armed_d = 1'b1;
      end
   end

   // Hysteresis arming flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed_q <= 1'b0;
      else        armed_q <= armed_d;
   end

   assign armed_c = armed_q;
`else
   assign armed_c = in_wait_i;
`endif

   // Crossing compare against the stored previous sample
   always_comb begin
      if (falling_i) cross_c = (prev_q >= level_i) && (sample_i <  level_i);
      else           cross_c = (prev_q <  level_i) && (sample_i >= level_i);
      hit_c = sample_en_i && valid_q && armed_c && cross_c;
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger/acquisition sequencer for the 8-bit ADC sample RAM write port.
// Optional trigger hysteresis: define ADC_TRIG_HYST_EN.
module adc_capture_ctrl
   import adc_pkg::*;
#(
   parameter int unsigned DEPTH        = DEF_DEPTH,
   parameter int unsigned PRE_TRIG     = DEF_PRE_TRIG,
   parameter int unsigned AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
`ifdef ADC_TRIG_HYST_EN
   ,parameter int unsigned HYST        = DEF_HYST
`endif
) (
   input logic               clk_100MHz,
   input logic               Rst,
   adc_capture_ctrl_if.slave cap_if
);

   localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;
   localparam int unsigned TO_W     = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

   state_e          state_q, state_d;
   addr_t           ptr_q, ptr_d;
   addr_t           cnt_q, cnt_d;
   logic [TO_W-1:0] to_q, to_d;
   wr_port_t        wr_q, wr_d;
   logic            done_q, done_d;
   addr_t           start_q, start_d;
   logic            forced_q, forced_d;
   logic            busy_q, busy_d;

   logic            write_c;
   logic            pv_clr_c;
   logic            trig_hit_c;

   adc_trig_detect
`ifdef ADC_TRIG_HYST_EN
      #(.HYST(HYST))
`endif
      u_trig (
         .clk         (clk_100MHz),
         .rst_n       (Rst),
         .sample_en_i (cap_if.sample_en),
         .sample_i    (cap_if.adc_data),
         .level_i     (cap_if.trig_level),
         .falling_i   (cap_if.trig_falling),
         .busy_i      (state_q != ST_IDLE),
         .in_wait_i   (state_q == ST_WAIT_TRIG),
         .clr_i       (pv_clr_c),
         .hit_c       (trig_hit_c)
      );

   // Next-state, write port and status logic
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      to_d     = to_q;
      wr_d     = wr_q;
      wr_d.en  = 1'b0;
      done_d   = done_q;
      start_d  = start_q;
      forced_d = forced_q;
      write_c  = 1'b0;
      pv_clr_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cap_if.arm) begin
               cnt_d    = '0;
               to_d     = '0;
               pv_clr_c = 1'b1;
               state_d  = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PREFILL;
            end
         end
         ST_PREFILL: begin
            if (cap_if.sample_en) begin
               write_c = 1'b1;
               if (cnt_q == ADDR_W'(PRE_TRIG - 1)) begin
                  cnt_d   = '0;
                  to_d    = '0;
                  state_d = ST_WAIT_TRIG;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT_TRIG: begin
            if (cap_if.sample_en) begin
               write_c = 1'b1;
               if (cap_if.auto_mode) to_d = to_q + 1'b1;
               if (trig_hit_c ||
                   (cap_if.auto_mode && (to_q == TO_W'(AUTO_TIMEOUT - 1)))) begin
                  forced_d = !trig_hit_c;
                  start_d  = addr_sub_mod(ptr_q, PRE_TRIG, DEPTH);
                  cnt_d    = '0;
                  if (POST_LEN == 0) begin
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_POST;
                  end
               end
            end
         end
         ST_POST: begin
            if (cap_if.sample_en) begin
               write_c = 1'b1;
               if (cnt_q == ADDR_W'(POST_LEN - 1)) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (cap_if.frame_ack) begin
               done_d = 1'b0;
               cnt_d  = '0;
               to_d   = '0;
               if (cap_if.single) begin
                  state_d = ST_IDLE;
               end else begin
                  pv_clr_c = 1'b1;
                  state_d  = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PREFILL;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (write_c) begin
         wr_d.en   = 1'b1;
         wr_d.addr = ptr_q;
         wr_d.data = cap_if.adc_data;
         ptr_d     = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end

      // Abort wins over everything: drop the write, keep the pointer, clear status
      if (cap_if.abort) begin
         state_d  = ST_IDLE;
         wr_d.en  = 1'b0;
         ptr_d    = ptr_q;
         done_d   = 1'b0;
         forced_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_100MHz or negedge Rst) begin
      if (!Rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         wr_q     <= '0;
         done_q   <= 1'b0;
         start_q  <= '0;
         forced_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         wr_q     <= wr_d;
         done_q   <= done_d;
         start_q  <= start_d;
         forced_q <= forced_d;
         busy_q   <= busy_d;
      end
   end

   assign cap_if.wr_en        = wr_q.en;
   assign cap_if.wr_addr      = wr_q.addr;
   assign cap_if.wr_data      = wr_q.data;
   assign cap_if.capture_done = done_q;
   assign cap_if.start_addr   = start_q;
   assign cap_if.trig_forced  = forced_q;
   assign cap_if.busy         = busy_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=8,
// one sample strobe every third cycle.
module tb_adc_capture_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic        last_en;
   logic [15:0] last_addr;
   logic [7:0]  last_data;

   adc_capture_ctrl_if cap_if ();

   adc_capture_ctrl #(
      .DEPTH        (16),
      .PRE_TRIG     (4),
      .AUTO_TIMEOUT (8)
`ifdef ADC_TRIG_HYST_EN
      ,.HYST        (4)
`endif
   ) dut (
      .clk_100MHz (clk),
      .Rst        (rst_n),
      .cap_if     (cap_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One strobe, then two idle cycles; captures the registered write port
   task automatic strobe(input logic [7:0] v);
      cap_if.adc_data  = v;
      cap_if.sample_en = 1'b1;
      @(negedge clk);
      cap_if.sample_en = 1'b0;
      last_en   = cap_if.wr_en;
      last_addr = cap_if.wr_addr;
      last_data = cap_if.wr_data;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic ctl(input logic a, input logic k, input logic b);
      cap_if.arm       = a;
      cap_if.frame_ack = k;
      cap_if.abort     = b;
      @(negedge clk);
      cap_if.arm       = 1'b0;
      cap_if.frame_ack = 1'b0;
      cap_if.abort     = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: run did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n               = 1'b0;
      cap_if.sample_en    = 1'b0;
      cap_if.adc_data     = '0;
      cap_if.trig_level   = 8'd35;
      cap_if.trig_falling = 1'b0;
      cap_if.auto_mode    = 1'b0;
      cap_if.single       = 1'b1;
      cap_if.arm          = 1'b0;
      cap_if.abort        = 1'b0;
      cap_if.frame_ack    = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wr_en", cap_if.wr_en, 0);
      check("rst_wr_addr", cap_if.wr_addr, 0);
      check("rst_done", cap_if.capture_done, 0);
      check("rst_busy", cap_if.busy, 0);
      check("rst_start", cap_if.start_addr, 0);
      check("rst_forced", cap_if.trig_forced, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Rising ramp: trigger on 40 at addr 4, start 0
      ctl(1, 0, 0);
      check("ramp_busy", cap_if.busy, 1);
      for (int i = 0; i < 4; i++) strobe(8'(i * 10));
      check("ramp_pre_addr", last_addr, 3);
      strobe(8'd40);
      check("ramp_trig_en", last_en, 1);
      check("ramp_trig_addr", last_addr, 4);
      check("ramp_trig_data", last_data, 40);
      for (int i = 0; i < 10; i++) strobe(8'(50 + i * 10));
      check("ramp_not_done", cap_if.capture_done, 0);
      strobe(8'd150);
      check("ramp_last_addr", last_addr, 15);
      check("ramp_done", cap_if.capture_done, 1);
      check("ramp_start", cap_if.start_addr, 0);
      check("ramp_forced", cap_if.trig_forced, 0);
      strobe(8'd99);
      check("done_no_write", last_en, 0);
      ctl(0, 1, 0);
      check("ack_done_low", cap_if.capture_done, 0);
      check("ack_single_idle", cap_if.busy, 0);

      // Auto mode, two frames: forced on 8th WAIT_TRIG strobe
      cap_if.auto_mode  = 1'b1;
      cap_if.trig_level = 8'h90;
      for (int f = 0; f < 2; f++) begin
         ctl(1, 0, 0);
         repeat (12) strobe(8'h80);
         check("auto_force_addr", last_addr, (f == 0) ? 11 : 2);
         repeat (10) strobe(8'h80);
         check("auto_not_done", cap_if.capture_done, 0);
         strobe(8'h80);
         check("auto_done", cap_if.capture_done, 1);
         check("auto_start", cap_if.start_addr, (f == 0) ? 7 : 14);
         check("auto_forced", cap_if.trig_forced, 1);
         ctl(0, 1, 0);
      end

      // Pointer at 14: wrap during prefill, trigger at 3 -> start 15
      cap_if.auto_mode  = 1'b0;
      cap_if.trig_level = 8'd35;
      ctl(1, 0, 0);
      strobe(8'd0);
      check("wrap_addr14", last_addr, 14);
      strobe(8'd0);
      check("wrap_addr15", last_addr, 15);
      strobe(8'd0);
      check("wrap_addr0", last_addr, 0);
      strobe(8'd0);
      check("forced_held", cap_if.trig_forced, 1);
      strobe(8'd0);
      strobe(8'd50);
      check("wrap_trig_addr", last_addr, 3);
      repeat (11) strobe(8'd0);
      check("wrap_done", cap_if.capture_done, 1);
      check("wrap_start", cap_if.start_addr, 15);
      check("forced_cleared", cap_if.trig_forced, 0);
      ctl(0, 1, 0);

      // Continuous mode: ack re-arms; abort with ack goes idle
      cap_if.single = 1'b0;
      ctl(1, 0, 0);
      for (int f = 0; f < 2; f++) begin
         repeat (4) strobe(8'd0);
         strobe(8'd40);
         check("cont_trig_addr", last_addr, 3);
         repeat (11) strobe(8'd0);
         check("cont_done", cap_if.capture_done, 1);
         check("cont_start", cap_if.start_addr, 15);
         if (f == 0) begin
            ctl(0, 1, 0);
            check("cont_rearm_done", cap_if.capture_done, 0);
            check("cont_rearm_busy", cap_if.busy, 1);
         end else begin
            ctl(0, 1, 1);
            check("abort_ack_done", cap_if.capture_done, 0);
            check("abort_ack_busy", cap_if.busy, 0);
         end
      end
      cap_if.single = 1'b1;

      // No auto mode, no crossing: never completes
      cap_if.trig_level = 8'h90;
      ctl(1, 0, 0);
      repeat (24) strobe(8'h80);
      check("noauto_not_done", cap_if.capture_done, 0);
      check("noauto_busy", cap_if.busy, 1);
      ctl(0, 0, 1);
      check("abort_idle", cap_if.busy, 0);

      // Falling edge at the level boundary: 35 is not below 35, 34 is
      cap_if.trig_falling = 1'b1;
      cap_if.trig_level   = 8'd35;
      ctl(1, 0, 0);
      repeat (5) strobe(8'd35);
      check("fall_eq_addr", last_addr, 11);
      strobe(8'd34);
      check("fall_trig_addr", last_addr, 12);
      check("fall_trig_data", last_data, 34);
      repeat (11) strobe(8'd34);
      check("fall_done", cap_if.capture_done, 1);
      check("fall_start", cap_if.start_addr, 8);
      ctl(0, 1, 0);
      cap_if.trig_falling = 1'b0;

      // Reset mid-POST
      ctl(1, 0, 0);
      repeat (4) strobe(8'd0);
      strobe(8'd40);
      check("midpost_trig_addr", last_addr, 12);
      repeat (3) strobe(8'd60);
      check("midpost_busy", cap_if.busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_wr_en", cap_if.wr_en, 0);
      check("midrst_wr_addr", cap_if.wr_addr, 0);
      check("midrst_busy", cap_if.busy, 0);
      check("midrst_start", cap_if.start_addr, 0);
      check("midrst_done", cap_if.capture_done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Noise around level 50
      cap_if.trig_level = 8'd50;
      ctl(1, 0, 0);
      strobe(8'd0);
      check("noise_ptr_reset", last_addr, 0);
      repeat (3) strobe(8'd0);
`ifdef ADC_TRIG_HYST_EN
      strobe(8'd49);
      strobe(8'd51);
      strobe(8'd49);
      strobe(8'd51);
      strobe(8'd45);
      strobe(8'd51);
      check("hyst_trig_addr", last_addr, 9);
      repeat (10) strobe(8'd51);
      check("hyst_not_done", cap_if.capture_done, 0);
      strobe(8'd51);
      check("hyst_done", cap_if.capture_done, 1);
      check("hyst_start", cap_if.start_addr, 5);
`else
      strobe(8'd49);
      strobe(8'd51);
      check("noise_trig_addr", last_addr, 5);
      repeat (10) strobe(8'd51);
      check("noise_not_done", cap_if.capture_done, 0);
      strobe(8'd51);
      check("noise_done", cap_if.capture_done, 1);
      check("noise_start", cap_if.start_addr, 1);
`endif
      ctl(0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
